truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that exhaustively exercises a combinational 4-input boolean function block (x, y, w, z -> s) in the Guia04 sum-of-products family. On a start request it steps through every input vector, waits a settle interval, samples the function output, and assembles the captured truth table (minterm mask). It then compares the table against an expected mask and reports the result with a done pulse. It sits between a test controller or host register block and one function-under-test instance.

## Interface
- `N_IN`, default 4: number of function inputs. The block sweeps 2^N_IN vectors.
- `SETTLE`, default 1, minimum 1: cycles each vector is held before its sample cycle.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: begin a sweep. Honoured only in IDLE.
- `abort` input, 1 bit: synchronous cancel of a running sweep.
- `expected` input, 2^N_IN bits: expected minterm mask. Bit k is the output for vector k.
- `vec_out` output, N_IN bits: drives the function inputs. The MSB is x, then y, w, and the LSB is z.
- `s_in` input, 1 bit: function output.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `done` output, 1 bit: one-cycle pulse when a sweep completes.
- `table_out` output, 2^N_IN bits: captured minterm mask.
- `match` output, 1 bit: high when table_out equals the latched expected mask.
- `mismatch_count` output, N_IN+1 bits: number of differing vectors.
- `first_fail` output, N_IN bits: lowest mismatching vector index. It is 0 when match is high.

## Operation
- States:
  - IDLE: busy=0, vec_out=0.
  - DRIVE: vec_out=idx, held for SETTLE cycles.
  - SAMPLE: vec_out=idx, one cycle.
  - DONE: one cycle, done=1.
- IDLE -> DRIVE on a rising edge with start=1. On this edge the block:
  - latches `expected` into an internal register;
  - sets idx=0 and settle counter=0;
  - clears table, mismatch_count, first_fail, and a fail-seen flag.
- DRIVE: the settle counter increments each cycle. After SETTLE cycles the block moves to SAMPLE.
- SAMPLE edge:
  - Writes table[idx] <= s_in.
  - If s_in !== exp[idx]: increments mismatch_count. If no failure has been seen yet, sets first_fail=idx and sets fail-seen. An X or Z on s_in counts as a mismatch.
  - If idx = 2^N_IN-1, goes to DONE. Otherwise idx++, the settle counter clears, and the block returns to DRIVE.
- DONE -> IDLE unconditionally. `match` = (mismatch_count == 0), registered on entry to DONE.
- Result outputs (table_out, match, mismatch_count, first_fail) hold their values from DONE until the next accepted start. During a sweep they show partial values; they are valid only while done is high or after it.
- abort=1 in DRIVE or SAMPLE:
  - The next state is IDLE.
  - No done pulse is generated and no table write occurs that cycle.
  - match is forced to 0. Other results keep their partial values.
- abort has priority over a SAMPLE transition. abort in IDLE or DONE is ignored. When start and abort are high together in IDLE, start wins and abort is ignored.
- start while busy is ignored, and the latched expected mask does not change.
- The expected input may change freely after the start edge.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, vec_out=0, busy=0, done=0, table_out=0, match=0, mismatch_count=0, first_fail=0, idx=0.
- If reset is asserted mid-sweep, everything returns to these values and the sweep is not resumed.
- Edge E0 accepts start. busy rises after E0.
- Vector k appears on vec_out after edge E0 + k·(SETTLE+1).
- Vector k is sampled at edge E0 + (k+1)·(SETTLE+1).
- With the defaults, the last sample is at E32. done is high for the cycle after E32 and falls at E33, which is also where busy falls.
- Total sweep latency: 2^N_IN·(SETTLE+1) + 1 cycles from start acceptance to IDLE.
- A start held high through DONE is accepted at the first IDLE edge, so back-to-back sweeps have exactly one IDLE cycle between them.
- idx never wraps past 2^N_IN-1. mismatch_count maxes at 2^N_IN, which fits in N_IN+1 bits.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles, then release -> all outputs at their reset values; vec_out=0000; no done pulse.
- Golden sweep: connect the SoP reference function (minterms 1, 2, 4, 8, 10, 12, 14), expected=16'h5516, pulse start -> vec_out steps 0..15, with each value held 2 cycles; done pulses at E0+33; table_out=16'h5516, match=1, mismatch_count=0, first_fail=0.
- Mismatch sweep: same function with expected=16'h5517 and 16'hD516 in two runs -> run 1 gives count=1, first_fail=0; run 2 gives count=1, first_fail=15; match=0 in both runs.
- Settle timing: SETTLE=3 with the golden function -> each vector is held 4 cycles; done pulses at E0+65; results are identical to the golden sweep.
- Abort and restart: abort during the vector 7 DRIVE phase -> IDLE next cycle, no done pulse, match=0. Then a new start gives a full, correct sweep.
- Asynchronous reset mid-sweep and start-while-busy:
  - Pulse start again during vector 3 -> ignored.
  - Drop rst_n during vector 9 -> outputs clear immediately, without waiting for an edge.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational boolean block, samples its output after a
// settle interval, builds the minterm mask and compares it against a latched expected mask.
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   s_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [N_IN:0]          mismatch_count,
  output logic [N_IN-1:0]        first_fail
);
  localparam int NV = 1 << N_IN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic [NV-1:0]     tab_q, tab_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              seen_q, seen_d;
  logic              match_q, match_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              miss;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    tab_d    = tab_q;
    cnt_d    = cnt_q;
    ff_d     = ff_q;
    seen_d   = seen_q;
    match_d  = match_q;
    // Case-inequality so an undriven or unknown function output is reported as a failure.
    miss     = (s_in !== exp_q[idx_q]);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_DRIVE;
          exp_d    = expected;
          idx_d    = '0;
          settle_d = '0;
          tab_d    = '0;
          cnt_d    = '0;
          ff_d     = '0;
          seen_d   = 1'b0;
          match_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
          match_d = 1'b0;
        end else if (settle_q == SW'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          match_d = 1'b0;
        end else begin
          tab_d[idx_q] = s_in;
          if (miss) begin
            cnt_d = cnt_q + 1'b1;
            if (!seen_q) begin
              ff_d   = idx_q;
              seen_d = 1'b1;
            end
          end
          if (idx_q == N_IN'(NV - 1)) begin
            state_d = S_DONE;
            match_d = (cnt_d == '0);
          end else begin
            idx_d    = idx_q + 1'b1;
            settle_d = '0;
            state_d  = S_DRIVE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    vec_d  = (state_d == S_DRIVE || state_d == S_SAMPLE) ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      tab_q    <= '0;
      cnt_q    <= '0;
      ff_q     <= '0;
      seen_q   <= 1'b0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      tab_q    <= tab_d;
      cnt_q    <= cnt_d;
      ff_q     <= ff_d;
      seen_q   <= seen_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vec_q    <= vec_d;
    end
  end

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = tab_q;
  assign match          = match_q;
  assign mismatch_count = cnt_q;
  assign first_fail     = ff_q;
endmodule
